wfi_irq_sequencer: RTL and testbench

- Core-side controller that sequences WFI and machine-level interrupt entry for the pipeline.
- On WFI it drains the pipeline, stalls fetch, and sleeps until an enabled interrupt is pending. It then retires the WFI and, when globally enabled, arbitrates pending interrupts into a single trap request to the trap/CSR unit.
- With no enabled interrupts, WFI blocks forever; no implicit timeout unless configured.

---
 rtl/wfi_irq_sequencer.sv | 153 +++++++++++++++
 tb/tb_wfi_irq_sequencer.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wfi_irq_sequencer.sv
`timescale 1ns/1ps
// WFI / machine-interrupt entry sequencer: drains the pipe, sleeps until an
// enabled interrupt is pending, retires the WFI and raises a single trap request.
module wfi_irq_sequencer #(
    parameter int unsigned WFI_TIMEOUT = 0,
    parameter int unsigned CNT_W       = 32,
    parameter int unsigned XLEN        = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wfi_valid,
    input  logic             pipe_idle,
    input  logic [2:0]       irq_pending,
    input  logic [2:0]       irq_enable,
    input  logic             mstatus_mie,
    input  logic             trap_ack,
    output logic             stall,
    output logic             wfi_retire,
    output logic             trap_req,
    output logic [XLEN-1:0]  trap_cause,
    output logic             sleeping,
    output logic [CNT_W-1:0] sleep_cycles
);

    localparam int unsigned CODE_W = 4;
    localparam logic [CODE_W-1:0] CODE_MEI = 4'd11;
    localparam logic [CODE_W-1:0] CODE_MSI = 4'd3;
    localparam logic [CODE_W-1:0] CODE_MTI = 4'd7;
    localparam bit TO_EN = (WFI_TIMEOUT != 0);
    localparam logic [CNT_W-1:0] TO_LAST = TO_EN ? CNT_W'(WFI_TIMEOUT - 1) : '0;

    typedef enum logic [2:0] {
        ST_RUN,
        ST_DRAIN,
        ST_SLEEP,
        ST_WAKE,
        ST_TRAP
    } state_e;

    state_e            state_q, state_d;
    logic              stall_q, stall_d;
    logic              wfi_retire_q, wfi_retire_d;
    logic              trap_req_q, trap_req_d;
    logic [XLEN-1:0]   trap_cause_q, trap_cause_d;
    logic              sleeping_q, sleeping_d;
    logic [CNT_W-1:0]  sleep_cycles_q, sleep_cycles_d;
    logic [CNT_W-1:0]  to_cnt_q, to_cnt_d;

    logic [2:0]        pe;
    logic              wake;
    logic [CODE_W-1:0] irq_code;

    assign pe   = irq_pending & irq_enable;
    assign wake = |pe;

    // Fixed priority: external > software > timer.
    always_comb begin
        irq_code = CODE_MTI;
        if (pe[2]) begin
            irq_code = CODE_MEI;
        end else if (pe[0]) begin
            irq_code = CODE_MSI;
        end
    end

    always_comb begin
        state_d        = state_q;
        sleep_cycles_d = sleep_cycles_q;
        to_cnt_d       = to_cnt_q;
        trap_cause_d   = trap_cause_q;

        case (state_q)
            ST_RUN: begin
                if (wfi_valid) begin
                    state_d = ST_DRAIN;
                end else if (mstatus_mie && wake) begin
                    state_d = ST_TRAP;
                end
            end
            ST_DRAIN: begin
                if (pipe_idle) begin
                    state_d = wake ? ST_WAKE : ST_SLEEP;
                end
            end
            ST_SLEEP: begin
                if (sleep_cycles_q != {CNT_W{1'b1}}) begin
                    sleep_cycles_d = sleep_cycles_q + CNT_W'(1);
                end
                if (TO_EN) begin
                    to_cnt_d = to_cnt_q + CNT_W'(1);
                end
                if (wake || (TO_EN && (to_cnt_q == TO_LAST))) begin
                    state_d  = ST_WAKE;
                    to_cnt_d = '0;
                end
            end
            ST_WAKE: begin
                state_d = (mstatus_mie && wake) ? ST_TRAP : ST_RUN;
            end
            ST_TRAP: begin
                if (trap_ack) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase

        if ((state_q == ST_RUN) && (state_d == ST_DRAIN)) begin
            sleep_cycles_d = '0;
        end
        // Cause is committed once on TRAP entry and frozen until acknowledged.
        if ((state_q != ST_TRAP) && (state_d == ST_TRAP)) begin
            trap_cause_d = {1'b1, (XLEN-1)'(irq_code)};
        end

        stall_d      = (state_d != ST_RUN);
        wfi_retire_d = (state_d == ST_WAKE);
        trap_req_d   = (state_d == ST_TRAP);
        sleeping_d   = (state_d == ST_SLEEP);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= ST_RUN;
            stall_q        <= 1'b0;
            wfi_retire_q   <= 1'b0;
            trap_req_q     <= 1'b0;
            trap_cause_q   <= '0;
            sleeping_q     <= 1'b0;
            sleep_cycles_q <= '0;
            to_cnt_q       <= '0;
        end else begin
            state_q        <= state_d;
            stall_q        <= stall_d;
            wfi_retire_q   <= wfi_retire_d;
            trap_req_q     <= trap_req_d;
            trap_cause_q   <= trap_cause_d;
            sleeping_q     <= sleeping_d;
            sleep_cycles_q <= sleep_cycles_d;
            to_cnt_q       <= to_cnt_d;
        end
    end

    assign stall        = stall_q;
    assign wfi_retire   = wfi_retire_q;
    assign trap_req     = trap_req_q;
    assign trap_cause   = trap_cause_q;
    assign sleeping     = sleeping_q;
    assign sleep_cycles = sleep_cycles_q;

endmodule

// File: tb/tb_wfi_irq_sequencer.sv
`timescale 1ns/1ps
// Directed bench for wfi_irq_sequencer: vector table plus hand-written
// sleep, timeout and async-reset sequences.
module tb_wfi_irq_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        wfi_valid, pipe_idle, mstatus_mie, trap_ack;
    logic [2:0]  irq_pending, irq_enable;

    logic        stall, wfi_retire, trap_req, sleeping;
    logic [31:0] trap_cause, sleep_cycles;
    logic        to_stall, to_wfi_retire, to_trap_req, to_sleeping;
    logic [31:0] to_trap_cause, to_sleep_cycles;

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    wfi_irq_sequencer #(.WFI_TIMEOUT(0), .CNT_W(32), .XLEN(32)) dut (
        .clk(clk), .rst(rst), .wfi_valid(wfi_valid), .pipe_idle(pipe_idle),
        .irq_pending(irq_pending), .irq_enable(irq_enable), .mstatus_mie(mstatus_mie),
        .trap_ack(trap_ack), .stall(stall), .wfi_retire(wfi_retire), .trap_req(trap_req),
        .trap_cause(trap_cause), .sleeping(sleeping), .sleep_cycles(sleep_cycles)
    );

    wfi_irq_sequencer #(.WFI_TIMEOUT(8), .CNT_W(32), .XLEN(32)) dut_to (
        .clk(clk), .rst(rst), .wfi_valid(wfi_valid), .pipe_idle(pipe_idle),
        .irq_pending(irq_pending), .irq_enable(irq_enable), .mstatus_mie(mstatus_mie),
        .trap_ack(trap_ack), .stall(to_stall), .wfi_retire(to_wfi_retire), .trap_req(to_trap_req),
        .trap_cause(to_trap_cause), .sleeping(to_sleeping), .sleep_cycles(to_sleep_cycles)
    );

    typedef struct packed {
        logic       wfi;
        logic       idle;
        logic [2:0] pend;
        logic [2:0] en;
        logic       mie;
        logic       ack;
        logic       e_stall;
        logic       e_retire;
        logic       e_trap;
        logic       e_sleep;
        logic [3:0] e_code;
    } vec_t;

    localparam int unsigned NVEC = 22;
    vec_t vecs [NVEC];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        wfi_valid   = 1'b0;
        pipe_idle   = 1'b1;
        irq_pending = 3'b000;
        irq_enable  = 3'b000;
        mstatus_mie = 1'b0;
        trap_ack    = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
    endtask

    initial begin
        int bad;
        int n;
        logic [31:0] cause0;

        idle_inputs();
        rst = 1'b0;

        // Vector table: inputs applied before an edge, outputs expected after it.
        vecs[0]  = '{1'b0, 1'b1, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0};
        vecs[1]  = '{1'b1, 1'b1, 3'b001, 3'b111, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0};
        vecs[2]  = '{1'b0, 1'b1, 3'b001, 3'b111, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0};
        vecs[3]  = '{1'b0, 1'b1, 3'b001, 3'b111, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'd3};
        vecs[4]  = '{1'b0, 1'b1, 3'b001, 3'b111, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0};
        vecs[5]  = '{1'b0, 1'b1, 3'b000, 3'b111, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0};
        vecs[6]  = '{1'b0, 1'b1, 3'b011, 3'b011, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'd3};
        vecs[7]  = '{1'b0, 1'b1, 3'b000, 3'b011, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'd3};
        vecs[8]  = '{1'b0, 1'b1, 3'b000, 3'b011, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0};
        vecs[9]  = '{1'b0, 1'b1, 3'b010, 3'b111, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'd7};
        vecs[10] = '{1'b0, 1'b1, 3'b110, 3'b111, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'd7};
        vecs[11] = '{1'b0, 1'b1, 3'b000, 3'b111, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0};
        vecs[12] = '{1'b0, 1'b1, 3'b100, 3'b111, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0};
        vecs[13] = '{1'b1, 1'b0, 3'b000, 3'b100, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0};
        vecs[14] = '{1'b0, 1'b0, 3'b000, 3'b100, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0};
        vecs[15] = '{1'b0, 1'b1, 3'b000, 3'b100, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'd0};
        vecs[16] = '{1'b0, 1'b1, 3'b100, 3'b100, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0};
        vecs[17] = '{1'b0, 1'b1, 3'b100, 3'b100, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0};
        vecs[18] = '{1'b0, 1'b1, 3'b001, 3'b001, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'd3};
        vecs[19] = '{1'b1, 1'b1, 3'b001, 3'b001, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'd3};
        vecs[20] = '{1'b0, 1'b1, 3'b000, 3'b001, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0};
        vecs[21] = '{1'b0, 1'b1, 3'b000, 3'b001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0};

        // Reset state while rst is held low.
        #12;
        check("rst_stall", 64'(stall), 64'd0);
        check("rst_retire", 64'(wfi_retire), 64'd0);
        check("rst_trap", 64'(trap_req), 64'd0);
        check("rst_cause", 64'(trap_cause), 64'd0);
        check("rst_sleeping", 64'(sleeping), 64'd0);
        check("rst_sleep_cycles", 64'(sleep_cycles), 64'd0);

        do_reset();
        for (int i = 0; i < int'(NVEC); i++) begin
            wfi_valid   = vecs[i].wfi;
            pipe_idle   = vecs[i].idle;
            irq_pending = vecs[i].pend;
            irq_enable  = vecs[i].en;
            mstatus_mie = vecs[i].mie;
            trap_ack    = vecs[i].ack;
            tick();
            check($sformatf("vec%0d_stall", i), 64'(stall), 64'(vecs[i].e_stall));
            check($sformatf("vec%0d_retire", i), 64'(wfi_retire), 64'(vecs[i].e_retire));
            check($sformatf("vec%0d_trap", i), 64'(trap_req), 64'(vecs[i].e_trap));
            check($sformatf("vec%0d_sleeping", i), 64'(sleeping), 64'(vecs[i].e_sleep));
            if (vecs[i].e_trap) begin
                check($sformatf("vec%0d_cause", i), 64'(trap_cause),
                      64'(32'h8000_0000 | 32'(vecs[i].e_code)));
            end
        end

        // Interrupts disabled: WFI sleeps indefinitely.
        do_reset();
        irq_pending = 3'b111;
        wfi_valid   = 1'b1;
        tick();
        wfi_valid   = 1'b0;
        tick();
        bad = 0;
        for (int i = 0; i < 499; i++) begin
            if (sleeping !== 1'b1 || wfi_retire !== 1'b0 || trap_req !== 1'b0) bad++;
            tick();
        end
        if (sleeping !== 1'b1 || wfi_retire !== 1'b0 || trap_req !== 1'b0) bad++;
        check("dis_sleep_violations", 64'(bad), 64'd0);
        check("dis_sleep_cycles", 64'(sleep_cycles), 64'd499);
        check("dis_stall", 64'(stall), 64'd1);

        // Wake without trap: MTIE only, global enable off.
        do_reset();
        irq_enable = 3'b010;
        wfi_valid  = 1'b1;
        tick();
        wfi_valid  = 1'b0;
        tick();
        repeat (20) tick();
        check("nt_still_sleeping", 64'(sleeping), 64'd1);
        irq_pending = 3'b010;
        tick();
        check("nt_retire", 64'(wfi_retire), 64'd1);
        check("nt_sleeping_low", 64'(sleeping), 64'd0);
        check("nt_sleep_cycles", 64'(sleep_cycles), 64'd21);
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (wfi_retire !== 1'b0 || trap_req !== 1'b0 || stall !== 1'b0) bad++;
        end
        check("nt_run_no_trap", 64'(bad), 64'd0);

        // Wake with trap, all three pending: external interrupt wins.
        do_reset();
        irq_enable  = 3'b111;
        mstatus_mie = 1'b1;
        wfi_valid   = 1'b1;
        tick();
        wfi_valid   = 1'b0;
        tick();
        repeat (3) tick();
        irq_pending = 3'b111;
        tick();
        check("wt_retire", 64'(wfi_retire), 64'd1);
        check("wt_trap_not_yet", 64'(trap_req), 64'd0);
        tick();
        check("wt_trap", 64'(trap_req), 64'd1);
        check("wt_retire_pulse", 64'(wfi_retire), 64'd0);
        check("wt_cause", 64'(trap_cause), 64'h8000_000B);
        cause0 = trap_cause;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (trap_req !== 1'b1 || trap_cause !== cause0) bad++;
        end
        check("wt_cause_stable", 64'(bad), 64'd0);
        trap_ack    = 1'b1;
        irq_pending = 3'b000;
        tick();
        trap_ack    = 1'b0;
        check("wt_trap_dropped", 64'(trap_req), 64'd0);
        check("wt_stall_dropped", 64'(stall), 64'd0);

        // Timeout instance: drain for 4 cycles, then self-retire after 8 sleep cycles.
        do_reset();
        pipe_idle = 1'b0;
        wfi_valid = 1'b1;
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            wfi_valid = 1'b0;
            if (to_stall !== 1'b1 || to_sleeping !== 1'b0) bad++;
        end
        check("to_drain_stall", 64'(bad), 64'd0);
        pipe_idle = 1'b1;
        tick();
        check("to_sleep_entered", 64'(to_sleeping), 64'd1);
        n = 0;
        bad = 0;
        while (n < 20) begin
            tick();
            n++;
            if (to_stall !== 1'b1) bad++;
            if (to_wfi_retire === 1'b1) break;
        end
        check("to_retire_delay", 64'(n), 64'd8);
        check("to_stall_held", 64'(bad), 64'd0);
        check("to_no_timeout_inst", 64'(sleeping), 64'd1);
        tick();
        check("to_back_to_run", 64'(to_stall), 64'd0);

        // Asynchronous reset mid-TRAP.
        do_reset();
        irq_enable  = 3'b001;
        mstatus_mie = 1'b1;
        wfi_valid   = 1'b1;
        tick();
        wfi_valid   = 1'b0;
        tick();
        repeat (5) tick();
        irq_pending = 3'b001;
        tick();
        tick();
        check("ar_trap_before", 64'(trap_req), 64'd1);
        check("ar_sleep_cycles_before", 64'(sleep_cycles), 64'd6);
        #2;
        rst = 1'b0;
        #1;
        check("ar_trap_cleared", 64'(trap_req), 64'd0);
        check("ar_stall_cleared", 64'(stall), 64'd0);
        check("ar_sleep_cycles_cleared", 64'(sleep_cycles), 64'd0);
        check("ar_cause_cleared", 64'(trap_cause), 64'd0);
        idle_inputs();
        tick();
        tick();
        rst = 1'b1;
        tick();
        check("ar_post_run", 64'(stall), 64'd0);
        irq_pending = 3'b111;
        wfi_valid   = 1'b1;
        tick();
        wfi_valid   = 1'b0;
        tick();
        bad = 0;
        for (int i = 0; i < 30; i++) begin
            if (sleeping !== 1'b1 || wfi_retire !== 1'b0 || trap_req !== 1'b0) bad++;
            tick();
        end
        check("ar_fresh_wfi_sleeps", 64'(bad), 64'd0);
        check("ar_fresh_sleep_cycles", 64'(sleep_cycles), 64'd30);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
